// File: rtl/parity_serializer_if.sv
// Handshake and serial-output bundle between a word source and parity_serializer.
// Handshake: a word is accepted on any posedge where start && ready; start while ready is low is dropped, not queued.
interface parity_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic             inject_error;
  logic             ready;
  logic             serial_out;
  logic             chk_clear;
  logic             frame_active;
  logic             done;

  modport master (
    output data_in, start, inject_error,
    input  ready, serial_out, chk_clear, frame_active, done
  );

  modport slave (
    input  data_in, start, inject_error,
    output ready, serial_out, chk_clear, frame_active, done
  );
endinterface

// File: rtl/parity_serializer.sv
// Shifts a WIDTH-bit word out LSB-first followed by one parity bit, framing it
// for a downstream serial parity checker (clear strobe before, verdict pulse after).
module parity_serializer #(
  parameter int WIDTH      = 8,
  parameter int ODD_PARITY = 1
) (
  input  logic               clk,
  input  logic               reset,
  parity_serializer_if.slave bus,
  output logic [1:0]         state_dbg
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               parity_q, parity_d;
  logic               done_q, done_d;
  logic               base_parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      done_q   <= done_d;
    end
  end

  // Parity bit makes the data+parity ones count odd (ODD_PARITY) or even.
  always_comb begin
    base_parity = (ODD_PARITY != 0) ? ~^bus.data_in : ^bus.data_in;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d  = bus.data_in;
          cnt_d    = '0;
          parity_d = base_parity ^ bus.inject_error;
          state_d  = DATA;
        end
      end
      DATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode from registered state so the checker sees clean levels.
  always_comb begin
    bus.ready        = (state_q == IDLE);
    bus.chk_clear    = (state_q == IDLE);
    bus.frame_active = (state_q == DATA) || (state_q == PARITY);
    bus.done         = done_q;
    bus.serial_out   = 1'b0;
    if (state_q == DATA) begin
      bus.serial_out = shift_q[0];
    end else if (state_q == PARITY) begin
      bus.serial_out = parity_q;
    end
  end

  assign state_dbg = state_q;
endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: directed and random frames, expected bit stream and
// checker verdicts queued at acceptance, compared by an independent negedge monitor.
module tb_parity_serializer;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  parity_serializer_if #(.WIDTH(W)) bus ();

  parity_serializer #(.WIDTH(W), .ODD_PARITY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic verdict_q[$];
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Reference: frame = data LSB-first, then the bit making the ones count odd,
  // inverted on injection. The checker flags an error exactly when injected.
  task automatic push_frame(input logic [W-1:0] d, input logic inj);
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    exp_q.push_back((($countones(d) % 2) == 0) ^ inj);
    verdict_q.push_back(inj);
  endtask

  task automatic send(input logic [W-1:0] d, input logic inj);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!bus.ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout at %0t: ready stayed %b, required 1", $time, bus.ready);
      return;
    end
    bus.data_in      = d;
    bus.inject_error = inj;
    bus.start        = 1'b1;
    @(posedge clk);
    push_frame(d, inj);
    #1;
    bus.start        = 1'b0;
    bus.data_in      = W'($urandom);
    bus.inject_error = 1'($urandom);
  endtask

  // Monitor with a behavioural checker: cleared while chk_clear, else accumulates ones.
  logic chk_odd = 1'b0;
  int   bit_cnt = 0;
  logic done_pending = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("done_timing", bus.done, done_pending);
      if (bus.done) begin
        if (verdict_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done at %0t: done=1, required no frame pending", $time);
        end else begin
          check("checker_verdict", ~chk_odd, verdict_q.pop_front());
        end
      end
      done_pending = 1'b0;
      check("ready", bus.ready, ~bus.frame_active);
      check("chk_clear", bus.chk_clear, ~bus.frame_active);
      if (!bus.frame_active) begin
        check("idle_serial", bus.serial_out, 1'b0);
        check("start_latency", exp_q.size() == 0, 1'b1);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame at %0t: frame_active=1, required 0", $time);
      end else begin
        check("serial_bit", bus.serial_out, exp_q.pop_front());
        bit_cnt++;
        if (bit_cnt == W + 1) begin
          bit_cnt      = 0;
          done_pending = 1'b1;
        end
      end
      chk_odd = bus.chk_clear ? 1'b0 : (chk_odd ^ bus.serial_out);
      if (reset) begin
        exp_q.delete();
        verdict_q.delete();
        bit_cnt      = 0;
        done_pending = 1'b0;
      end
    end
  end

  task automatic finish_report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog at %0t: simulation did not complete", $time);
    finish_report();
  end

  initial begin
    int budget;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.data_in      = '0;
    bus.inject_error = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    send(8'hA5, 1'b0);
    send(8'h07, 1'b0);
    send(8'h07, 1'b1);

    // Start while busy must be dropped.
    send(8'h55, 1'b0);
    repeat (3) @(negedge clk);
    bus.data_in = 8'hFF;
    bus.start   = 1'b1;
    repeat (3) @(negedge clk);
    bus.start   = 1'b0;

    send(8'h00, 1'b0);
    send(8'h01, 1'b0);

    // Reset while data bit 4 is on the wire.
    send(8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send(8'h3C, 1'b0);

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(W'($urandom), ($urandom_range(0, 3) == 0));
    end

    budget = 0;
    while ((exp_q.size() != 0 || verdict_q.size() != 0) && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0 || verdict_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout at %0t: %0d bits %0d verdicts left, required 0",
               $time, exp_q.size(), verdict_q.size());
    end
    repeat (4) @(posedge clk);
    finish_report();
  end
endmodule
